// File: rtl/frequency_analyzer_bank.sv
// frequency_analyzer_bank: per-channel pixel-MSB period binning with valid/ready result dump.
// Optional FREQUENCY_ANALYZER_BANK_SATURATE_EN makes accumulators saturate with a sticky overflow flag.
module frequency_analyzer_bank #(
  parameter int CHANNELS = 3,
  parameter int DATA_WIDTH = 8,
  parameter int INDEX_WIDTH = 10,
  parameter int COUNTER_WIDTH = 32,
  parameter int PERIOD0_MIN = 9050,
  parameter int PERIOD0_MAX = 9150,
  parameter int PERIOD1_MIN = 11000,
  parameter int PERIOD1_MAX = 11250
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    pixel_data,
  input  logic                     pixel_valid,
  input  logic                     line_start,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     cfg_we,
  input  logic [2:0]               cfg_channel,
  input  logic [INDEX_WIDTH-1:0]   cfg_index,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [COUNTER_WIDTH-1:0] result_data,
  output logic [2:0]               result_channel,
  output logic                     result_bin,
  output logic                     result_last,
  output logic                     busy,
  output logic                     irq
);
  localparam int WORDS = 2 * CHANNELS;
  localparam int PW = $clog2(WORDS);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
`ifdef FREQUENCY_ANALYZER_BANK_SATURATE_EN
  localparam int SW = COUNTER_WIDTH + 1;
`else
  localparam int SW = COUNTER_WIDTH;
`endif
  localparam logic [COUNTER_WIDTH-1:0] P0L = COUNTER_WIDTH'(PERIOD0_MIN);
  localparam logic [COUNTER_WIDTH-1:0] P0H = COUNTER_WIDTH'(PERIOD0_MAX);
  localparam logic [COUNTER_WIDTH-1:0] P1L = COUNTER_WIDTH'(PERIOD1_MIN);
  localparam logic [COUNTER_WIDTH-1:0] P1H = COUNTER_WIDTH'(PERIOD1_MAX);
  typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;
  state_t state, state_n;
  logic [INDEX_WIDTH-1:0] idx [CHANNELS];
  logic [INDEX_WIDTH-1:0] pix, pos;
  logic [CHANNELS-1:0] sample, sample_d, armed, rise, hit, sel;
  logic [COUNTER_WIDTH-1:0] cnt [CHANNELS];
  logic [COUNTER_WIDTH-1:0] acc [CHANNELS][2];
  logic [SW-1:0] sum [CHANNELS];
  logic [PW-1:0] word;
  logic [CW-1:0] wch;
  logic hs, irq_r, unused;
`ifdef FREQUENCY_ANALYZER_BANK_SATURATE_EN
  logic [CHANNELS-1:0] ovf;
  assign result_data = state != DUMP ? '0 : ovf[wch] ? '1 : acc[wch][word[0]];
`else
  assign result_data = state != DUMP ? '0 : acc[wch][word[0]];
`endif
  assign unused = ^pixel_data[DATA_WIDTH-2:0];
  assign wch = CW'(word >> 1);
  assign pos = line_start ? '0 : pix + 1'b1;
  assign result_valid = state == DUMP;
  assign result_channel = 3'(word >> 1);
  assign result_bin = word[0];
  assign result_last = state == DUMP && word == PW'(WORDS - 1);
  assign hs = result_valid && result_ready;
  assign busy = state == RUN || state == DUMP;
  assign irq = irq_r;
  always_comb begin
    state_n = state;
    if ((state == IDLE || state == DONE) && start) state_n = RUN;
    if (state == RUN && stop) state_n = DUMP;
    if (hs && result_last) state_n = DONE;
  end
  // bin 1 wins the select; the ranges never overlap so bin 0 is the fallback
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      rise[c] = sample[c] & ~sample_d[c];
      sel[c] = cnt[c] >= P1L && cnt[c] <= P1H;
      hit[c] = armed[c] && rise[c] && (sel[c] || (cnt[c] >= P0L && cnt[c] <= P0H));
      sum[c] = SW'(acc[c][sel[c]]) + SW'(cnt[c]);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pix <= '0;
      word <= '0;
      irq_r <= 1'b0;
      sample <= '0;
      sample_d <= '0;
      armed <= '0;
`ifdef FREQUENCY_ANALYZER_BANK_SATURATE_EN
      ovf <= '0;
`endif
      for (int c = 0; c < CHANNELS; c++) begin
        idx[c] <= '0;
        cnt[c] <= '0;
        acc[c][0] <= '0;
        acc[c][1] <= '0;
      end
    end else begin
      state <= state_n;
      irq_r <= hs && result_last;
      sample_d <= sample;
      word <= state != DUMP ? '0 : hs ? word + 1'b1 : word;
      for (int c = 0; c < CHANNELS; c++)
        if (state == IDLE && cfg_we && cfg_channel == 3'(c)) idx[c] <= cfg_index;
      if (state_n == RUN && state != RUN) begin
        pix <= '0;
        sample <= '0;
        sample_d <= '0;
        armed <= '0;
`ifdef FREQUENCY_ANALYZER_BANK_SATURATE_EN
        ovf <= '0;
`endif
        for (int c = 0; c < CHANNELS; c++) begin
          cnt[c] <= '0;
          acc[c][0] <= '0;
          acc[c][1] <= '0;
        end
      end else if (state == RUN) begin
        if (pixel_valid) pix <= pos;
        for (int c = 0; c < CHANNELS; c++) begin
          if (pixel_valid && idx[c] == pos) sample[c] <= pixel_data[DATA_WIDTH-1];
          if (rise[c]) begin
            cnt[c] <= COUNTER_WIDTH'(1);
            armed[c] <= 1'b1;
          end else if (~&cnt[c]) begin
            cnt[c] <= cnt[c] + 1'b1;
          end
`ifdef FREQUENCY_ANALYZER_BANK_SATURATE_EN
          if (hit[c]) begin
            acc[c][sel[c]] <= sum[c][COUNTER_WIDTH] ? '1 : sum[c][COUNTER_WIDTH-1:0];
            if (sum[c][COUNTER_WIDTH]) ovf[c] <= 1'b1;
          end
`else
          if (hit[c]) acc[c][sel[c]] <= sum[c];
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_frequency_analyzer_bank.sv
// tb_frequency_analyzer_bank: scoreboard bench for a 32-bit and a 16-bit analyzer sharing one stimulus stream.
module tb_frequency_analyzer_bank;
  logic clock = 1'b0;
  logic reset, pixel_valid, line_start, start, stop, cfg_we, result_ready;
  logic [7:0] pixel_data;
  logic [2:0] cfg_channel;
  logic [9:0] cfg_index;
  logic result_valid, result_bin, result_last, busy, irq;
  logic [31:0] result_data;
  logic [2:0] result_channel;
  logic s_valid, s_bin, s_last, s_busy, s_irq;
  logic [15:0] s_data;
  logic [2:0] s_channel;
  typedef struct {logic [31:0] d; logic [2:0] ch; logic b; logic l;} word_t;
  word_t q_main[$], q_small[$];
  logic [31:0] em [6], es [6];
  int passed = 0, total = 0, hs_cnt = 0, irq_cnt = 0;
  logic irq_due = 1'b0, cur0 = 1'b0;
  longint cyc = 0, base;
  int ev_t [27] = '{2000, 5000, 6000, 6700, 11100, 14100, 17000, 17700, 20200, 23200, 28250, 28950, 29300,
                    32300, 38400, 39501, 40201, 41400, 47500, 48550, 49250, 50500, 56600, 59600, 65700, 68700, 74800};
  int ev_c [27] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
  logic ev_v [27] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1};

  frequency_analyzer_bank dut (
    .clock(clock), .reset(reset), .pixel_data(pixel_data), .pixel_valid(pixel_valid), .line_start(line_start),
    .start(start), .stop(stop), .cfg_we(cfg_we), .cfg_channel(cfg_channel), .cfg_index(cfg_index),
    .result_valid(result_valid), .result_ready(result_ready), .result_data(result_data),
    .result_channel(result_channel), .result_bin(result_bin), .result_last(result_last), .busy(busy), .irq(irq));

  frequency_analyzer_bank #(.COUNTER_WIDTH(16)) dut16 (
    .clock(clock), .reset(reset), .pixel_data(pixel_data), .pixel_valid(pixel_valid), .line_start(line_start),
    .start(start), .stop(stop), .cfg_we(cfg_we), .cfg_channel(cfg_channel), .cfg_index(cfg_index),
    .result_valid(s_valid), .result_ready(result_ready), .result_data(s_data),
    .result_channel(s_channel), .result_bin(s_bin), .result_last(s_last), .busy(s_busy), .irq(s_irq));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic chk_w(input string name, input word_t a, input word_t e);
    total++;
    if (a.d === e.d && a.ch === e.ch && a.b === e.b && a.l === e.l) passed++;
    else $display("FAIL %s: got data=%0d ch=%0d bin=%0d last=%0d expected data=%0d ch=%0d bin=%0d last=%0d",
                  name, a.d, a.ch, a.b, a.l, e.d, e.ch, e.b, e.l);
  endtask

  task automatic push_exp();
    for (int i = 0; i < 6; i++) begin
      q_main.push_back('{em[i], 3'(i / 2), 1'(i % 2), i == 5});
      q_small.push_back('{es[i], 3'(i / 2), 1'(i % 2), i == 5});
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // walk the pixel counter up to the channel's index, then land one pixel there at cycle t
  task automatic fire(input int ch, input logic v, input longint t);
    int tgt;
    tgt = ch == 0 ? 15 : 511;
    for (int p = 0; p < tgt; p++) begin
      pixel_valid = 1'b1;
      line_start = p == 0;
      pixel_data = p == 15 ? {cur0, 7'd0} : 8'd0;
      tick();
    end
    pixel_valid = 1'b0;
    line_start = 1'b0;
    chk("event_on_time", 32'(cyc <= t), 32'd1);
    while (cyc < t) tick();
    pixel_valid = 1'b1;
    pixel_data = {v, 7'd0};
    tick();
    pixel_valid = 1'b0;
    pixel_data = 8'd0;
    if (ch == 0) cur0 = v;
  endtask

  always @(negedge clock) begin
    if (irq || irq_due) chk("irq_pulse", 32'(irq), 32'(irq_due));
    if (irq) irq_cnt++;
    irq_due = result_valid && result_ready && result_last;
    if (result_valid) begin
      if (q_main.size() == 0) begin
        total++;
        $display("FAIL main_extra_word: got data=%0d ch=%0d expected no word", result_data, result_channel);
      end else begin
        chk_w("main_word", '{result_data, result_channel, result_bin, result_last}, q_main[0]);
        if (result_ready) begin
          void'(q_main.pop_front());
          hs_cnt++;
        end
      end
    end
    if (s_valid) begin
      if (q_small.size() == 0) begin
        total++;
        $display("FAIL small_extra_word: got data=%0d ch=%0d expected no word", s_data, s_channel);
      end else begin
        chk_w("small_word", '{{16'd0, s_data}, s_channel, s_bin, s_last}, q_small[0]);
        if (result_ready) void'(q_small.pop_front());
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pixel_valid = 1'b0; line_start = 1'b0; pixel_data = 8'd0; start = 1'b0; stop = 1'b0;
    cfg_we = 1'b0; cfg_channel = 3'd0; cfg_index = 10'd0; result_ready = 1'b0;
    tick();
    tick();
    @(negedge clock);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_data", result_data, 0);
    chk("rst_channel", 32'(result_channel), 0);
    chk("rst_bin", 32'(result_bin), 0);
    chk("rst_last", 32'(result_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_small_valid", 32'(s_valid), 0);
    tick();
    reset = 1'b0;
    cfg_we = 1'b1; cfg_channel = 3'd1; cfg_index = 10'd511; tick();
    cfg_channel = 3'd2; cfg_index = 10'd1023; tick();
    cfg_channel = 3'd5; cfg_index = 10'd7; tick();
    cfg_channel = 3'd0; cfg_index = 10'd15; start = 1'b1; tick();
    cfg_we = 1'b0; start = 1'b0;
    base = cyc;
    @(negedge clock);
    chk("busy_in_run", 32'(busy), 1);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    cfg_we = 1'b1; cfg_channel = 3'd0; cfg_index = 10'd100; tick(); cfg_we = 1'b0;
    for (int i = 0; i < 27; i++) fire(ev_c[i], ev_v[i], base + longint'(ev_t[i]));
    while (cyc < base + 74810) tick();
    em = '{32'd72800, 0, 0, 32'd22250, 0, 0};
`ifdef FREQUENCY_ANALYZER_BANK_SATURATE_EN
    es = '{32'd65535, 32'd65535, 0, 32'd22250, 0, 0};
`else
    es = '{32'd7264, 0, 0, 32'd22250, 0, 0};
`endif
    push_exp();
    stop = 1'b1;
    @(negedge clock);
    chk("valid_before_dump", 32'(result_valid), 0);
    tick();
    stop = 1'b0;
    @(negedge clock);
    chk("valid_after_stop", 32'(result_valid), 1);
    tick();
    for (int i = 0; i < 60 && hs_cnt < 6; i++) begin
      result_ready = i % 3 == 0;
      start = i == 1;
      stop = i == 2;
      tick();
    end
    result_ready = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (3) tick();
    chk("dump1_handshakes", 32'(hs_cnt), 6);
    chk("dump1_irq_count", 32'(irq_cnt), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_valid", 32'(result_valid), 0);
    stop = 1'b1; tick(); stop = 1'b0;
    @(negedge clock);
    chk("stop_in_done", 32'(busy), 0);
    em = '{0, 0, 0, 0, 0, 0};
    es = '{0, 0, 0, 0, 0, 0};
    push_exp();
    tick();
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; tick(); stop = 1'b0;
    result_ready = 1'b1; tick(); tick();
    result_ready = 1'b0;
    @(negedge clock);
    chk("dump2_handshakes", 32'(hs_cnt), 8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q_main.delete();
    q_small.delete();
    @(negedge clock);
    chk("abort_valid", 32'(result_valid), 0);
    chk("abort_irq", 32'(irq), 0);
    chk("abort_busy", 32'(busy), 0);
    tick();
    push_exp();
    start = 1'b1; tick(); start = 1'b0;
    stop = 1'b1; result_ready = 1'b1;
    @(negedge clock);
    chk("run3_valid_before_dump", 32'(result_valid), 0);
    @(posedge clock);
    #1 stop = 1'b0;
    repeat (6) @(negedge clock);
    chk("run3_last_on_word6", 32'(result_last), 1);
    @(negedge clock);
    chk("run3_irq_after_last", 32'(irq), 1);
    @(negedge clock);
    chk("run3_irq_one_cycle", 32'(irq), 0);
    chk("total_handshakes", 32'(hs_cnt), 14);
    chk("total_irqs", 32'(irq_cnt), 2);
    chk("queues_drained", 32'(q_main.size() + q_small.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/frequency_analyzer_bank.md
# frequency_analyzer_bank

Parametrised multi-channel successor to the three-pixel frequency analyzer manager. Samples the MSB of a configurable pixel index per channel on every line and measures the period between rising edges of each sampled bit. Accumulates the time spent in two programmable period bins per channel, then streams all results out through a valid/ready port after `stop`. It sits between the pixel capture path and the AXI register/IRQ glue, in the single system clock domain.

## Interface
- `CHANNELS`, 3: number of monitored pixels, range 1..8.
- `DATA_WIDTH`, 8: pixel width. The sampled bit is `pixel_data[DATA_WIDTH-1]`.
- `INDEX_WIDTH`, 10: pixel-counter and index width.
- `COUNTER_WIDTH`, 32: width of the period counters and accumulators.
- `PERIOD0_MIN`, 9050: inclusive lower bound of bin 0, in clock cycles.
- `PERIOD0_MAX`, 9150: inclusive upper bound of bin 0, in clock cycles.
- `PERIOD1_MIN`, 11000: inclusive lower bound of bin 1, in clock cycles.
- `PERIOD1_MAX`, 11250: inclusive upper bound of bin 1, in clock cycles.
- Bin ranges must not overlap. All bounds must be less than 2^COUNTER_WIDTH.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pixel_data` in DATA_WIDTH: pixel value.
- `pixel_valid` in 1: pixel strobe.
- `line_start` in 1: qualifies the first pixel of a line; only meaningful together with `pixel_valid`.
- `start` in 1: level-sampled run request.
- `stop` in 1: level-sampled end-of-run request.
- `cfg_we` in 1: index write strobe.
- `cfg_channel` in 3: target channel for the index write.
- `cfg_index` in INDEX_WIDTH: pixel index for the target channel.
- `result_valid` out 1: result word available.
- `result_ready` in 1: consumer accepts the result word.
- `result_data` out COUNTER_WIDTH: accumulated cycles.
- `result_channel` out 3: channel of the current result word.
- `result_bin` out 1: bin of the current result word.
- `result_last` out 1: marks the final result word.
- `busy` out 1: high in RUN and DUMP.
- `irq` out 1: one-cycle pulse when the dump completes.

## Operation
States: IDLE, RUN, DUMP, DONE.

**IDLE**
- `cfg_we` with `cfg_channel < CHANNELS` writes `index[cfg_channel]`. Out-of-range channels are ignored.
- `cfg_we` is ignored in every other state.
- `start` enters RUN.

**Entering RUN**
- Clears all accumulators, samples, armed flags, period counters and the pixel counter.

**RUN: pixel counting**
- On `pixel_valid`, the pixel counter holds the current pixel's position: 0 if `line_start`, otherwise previous+1, wrapping at 2^INDEX_WIDTH.
- For every channel whose index equals that position, `sample[ch]` is set to the pixel MSB.

**RUN: period measurement, per channel**
- A rising edge is `sample` going 0→1 between consecutive clocks.
- The period counter increments every clock and saturates at all-ones.
- On a rising edge:
  - If armed and the counter value P is in bin 0 or bin 1, that bin's accumulator += P.
  - Out-of-range P is discarded.
  - The counter then reloads to 1 and the channel becomes armed.
- The first edge after start only arms the channel.

**Leaving RUN**
- `stop` in RUN enters DUMP. `start` is ignored in RUN.

**DUMP**
- Emits 2·CHANNELS words in order: ch0/bin0, ch0/bin1, ch1/bin0, …
- Each word is held stable until `result_valid && result_ready`.
- `result_last` is high on the final word only.
- The handshake of the last word enters DONE and pulses `irq`.
- `start` and `stop` are ignored in DUMP.

**DONE**
- Accumulators are retained.
- `start` enters RUN, which clears them.
- `stop` is ignored.

**Reset**
- At any point, including mid-RUN and mid-DUMP: state IDLE.
- All indices, accumulators, counters and samples reset to 0.
- A partially emitted dump is abandoned without `irq`.

## Timing
- Reset values: `result_valid`=0, `result_data`=0, `result_channel`=0, `result_bin`=0, `result_last`=0, `busy`=0, `irq`=0.
- Pixel to `sample`: 1 cycle.
- Sample edge to accumulator update: 1 cycle after `sample` changes.
- `stop` sampled at edge N puts the state in DUMP at N. `result_valid`=1 from N+1.
- Back-to-back words are produced with `result_ready` held high: one word per cycle.
- `irq` is asserted for exactly the cycle after the last handshake.
- Simultaneous rising edge and `stop` on the same clock: the update lands in the accumulator before the dump reads it.
- A `cfg_we` on the same clock as `start` in IDLE takes effect.

## Configuration
- `FREQUENCY_ANALYZER_BANK_SATURATE_EN`
  - Defined: accumulators saturate at all-ones instead of wrapping. A sticky per-channel overflow flag is set and is reported as `result_data` all-ones.
  - Undefined: accumulators wrap modulo 2^COUNTER_WIDTH and no overflow flag is built.

## Test plan
- Reset, write index 15/511/1023 to channels 0/1/2, then start. Toggle channel 0's pixel with rising edges 9100 cycles apart five times, then stop → ch0/bin0 = 36400; all other words 0; `result_last` on word 6; `irq` pulses once.
- Channel 1 periods of 11000, 11250, 11251 and 9049 → ch1/bin1 = 22250; ch1/bin0 = 0.
- Dump with `result_ready` toggled 1,0,0,1… → every word held stable while stalled; order and `result_last` unchanged; exactly 6 handshakes.
- Assert `reset` during the 3rd dump word → `result_valid`=0 and `irq`=0 on the next cycle. A new run reads all-zero results with indices 0.
- `start` and `stop` pulsed while in RUN/DUMP, and `cfg_we` pulsed in RUN → no state change and indices unchanged.
- `COUNTER_WIDTH`=16, accumulate 8 periods of 9100 → with the macro, ch0/bin0 = 65535; without it, ch0/bin0 = 72800 mod 65536 = 7264.
